// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, data/parity/stop, device ACK check.
// Optional watchdog on device clock gaps when PS2_HOST_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INHIBIT_CYCLES = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int CW             = $clog2(INHIBIT_CYCLES + 1);

  // IDLE wait request | INHIBIT clock held low | REQ start bit out, device not yet clocking
  // DATA data/parity/stop | ACK wait device ack on fall 11 | WAITIDLE wait for released bus
  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WAITIDLE} state_t;
  state_t state, state_nx;

  logic          clk_m, clk_s, clk_prev, data_m, data_s, fall;
  logic [7:0]    shreg, shreg_nx;
  logic          par, par_nx;
  logic [3:0]    bitn, bitn_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          clk_oe_nx, data_oe_nx, done_nx, error_nx;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  logic [19:0] wdog, wdog_nx;
`endif

  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_m       <= 1'b1;
      clk_s       <= 1'b1;
      clk_prev    <= 1'b1;
      data_m      <= 1'b1;
      data_s      <= 1'b1;
      fall        <= 1'b0;
      state       <= S_IDLE;
      shreg       <= '0;
      par         <= 1'b0;
      bitn        <= '0;
      cnt         <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      wdog        <= '0;
`endif
    end else begin
      clk_m       <= ps2_clk_i;
      clk_s       <= clk_m;
      clk_prev    <= clk_s;
      data_m      <= ps2_data_i;
      data_s      <= data_m;
      fall        <= clk_prev & ~clk_s;
      state       <= state_nx;
      shreg       <= shreg_nx;
      par         <= par_nx;
      bitn        <= bitn_nx;
      cnt         <= cnt_nx;
      ps2_clk_oe  <= clk_oe_nx;
      ps2_data_oe <= data_oe_nx;
      tx_done     <= done_nx;
      tx_error    <= error_nx;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      wdog        <= wdog_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    par_nx     = par;
    bitn_nx    = bitn;
    cnt_nx     = cnt;
    clk_oe_nx  = 1'b0;
    data_oe_nx = ps2_data_oe;
    done_nx    = 1'b0;
    error_nx   = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    wdog_nx    = wdog;
`endif
    case (state)
      S_IDLE: begin
        data_oe_nx = 1'b0;
        if (tx_valid) begin
          shreg_nx = tx_data;
          par_nx   = ~^tx_data;
          bitn_nx  = '0;
          cnt_nx   = CW'(INHIBIT_CYCLES - 1);
          state_nx = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt != '0) cnt_nx = cnt - CW'(1);
        else           state_nx = S_REQ;
      end
      S_REQ, S_DATA: begin
        if (fall) begin
          bitn_nx  = bitn + 4'd1;
          state_nx = S_DATA;
          if (bitn < 4'd8) begin
            data_oe_nx = ~shreg[0];
            shreg_nx   = {1'b0, shreg[7:1]};
          end else if (bitn == 4'd8) begin
            data_oe_nx = ~par;
          end else begin
            data_oe_nx = 1'b0;
            state_nx   = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fall) begin
          bitn_nx  = bitn + 4'd1;
          done_nx  = ~data_s;
          error_nx = data_s;
          state_nx = S_WAITIDLE;
        end
      end
      S_WAITIDLE: begin
        if (clk_s && data_s) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
    if (state inside {S_REQ, S_DATA, S_ACK, S_WAITIDLE}) begin
      if (wdog == '0) begin
        state_nx   = S_IDLE;
        data_oe_nx = 1'b0;
        done_nx    = 1'b0;
        error_nx   = 1'b1;
      end else if (fall) begin
        wdog_nx = 20'(TIMEOUT_CYCLES - 1);
      end else begin
        wdog_nx = wdog - 20'd1;
      end
    end
    if (state == S_INHIBIT && state_nx == S_REQ) wdog_nx = 20'(TIMEOUT_CYCLES - 1);
`endif

    // Data is pulled low already in the last inhibit cycle so the start bit is set up before clock release.
    clk_oe_nx = (state_nx == S_INHIBIT);
    if (state_nx == S_INHIBIT) data_oe_nx = (cnt_nx == '0);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device, table-driven and random byte transfers.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TO  = 300;
  localparam int H   = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.CLK_HZ(1_000_000), .INHIBIT_US(INH), .TIMEOUT_US(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int done_n = 0, err_n = 0, both_n = 0, last_done_cyc = 0, last_err_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tx_done) begin done_n <= done_n + 1; last_done_cyc <= cyc; end
    if (tx_error) begin err_n <= err_n + 1; last_err_cyc <= cyc; end
    if (tx_done && tx_error) both_n <= both_n + 1;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  // Frame as the device sees it: 8 data bits LSB first, odd parity, stop 1.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic wait_ready(input int bound);
    int t = 0;
    while (!tx_ready && t < bound) begin @(negedge clk); t++; end
    if (!tx_ready) chk("wait_ready_bound", 0, 1);
  endtask

  task automatic start_req(input logic [7:0] d);
    @(negedge clk); tx_data = d; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0; tx_data = ~d;
  endtask

  task automatic dev_falls(input int n);
    for (int k = 0; k < n; k++) begin
      dev_clk_low = 1'b1; repeat (H) @(negedge clk);
      dev_clk_low = 1'b0; repeat (H) @(negedge clk);
    end
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input logic [9:0] exp_frame, input bit exp_done);
    int d0, e0, b0, n_inh, dpos, t, f11;
    logic [9:0] got;
    wait_ready(200);
    d0 = done_n; e0 = err_n; b0 = both_n;
    start_req(d);
    n_inh = 0; dpos = 0; t = 0;
    while (ps2_clk_oe && t < 1000) begin
      n_inh++;
      if (ps2_data_oe && dpos == 0) dpos = n_inh;
      @(negedge clk); t++;
    end
    chk("inhibit_len", n_inh, INH);
    chk("inhibit_data_pos", dpos, INH);
    chk("start_bit", ps2_data_oe, 1);
    repeat (H) @(negedge clk);
    got = '0; f11 = 0;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      if (k == 11) f11 = cyc;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) got[k-1] = ps2_data_i;
      if (k == 10 && ack) begin repeat (H/2) @(negedge clk); dev_data_low = 1'b1; repeat (H - H/2) @(negedge clk); end
      else repeat (H) @(negedge clk);
    end
    dev_data_low = 1'b0;
    wait_ready(100);
    @(negedge clk);
    chk("frame", got, exp_frame);
    chk("done_count", done_n - d0, exp_done ? 1 : 0);
    chk("error_count", err_n - e0, exp_done ? 0 : 1);
    chk("done_error_overlap", both_n - b0, 0);
    if (exp_done) chk("done_latency", last_done_cyc - f11, 4);
    else          chk("error_latency", last_err_cyc - f11, 4);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_par;
    bit         exp_done;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int d0, e0, f3, t;
    logic [7:0] rd;
    bit ra;
    tbl[0] = '{8'hED, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{8'h01, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'hF4, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'hA5, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_tx_error", tx_error, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);

    foreach (tbl[i]) run_xfer(tbl[i].data, tbl[i].ack, {1'b1, tbl[i].exp_par, tbl[i].data}, tbl[i].exp_done);

    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      ra = ($urandom_range(0, 3) != 0);
      run_xfer(rd, ra, model_frame(rd), ra);
    end

    // Reset after the fifth device clock: lines drop immediately, no completion pulse.
    wait_ready(200);
    d0 = done_n; e0 = err_n;
    start_req(8'h5A);
    t = 0;
    while (ps2_clk_oe && t < 1000) begin @(negedge clk); t++; end
    repeat (H) @(negedge clk);
    dev_falls(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_clk_oe", ps2_clk_oe, 0);
    chk("midrst_data_oe", ps2_data_oe, 0);
    chk("midrst_tx_ready", tx_ready, 1);
    repeat (30) @(negedge clk);
    chk("midrst_no_done", done_n - d0, 0);
    chk("midrst_no_error", err_n - e0, 0);
    run_xfer(8'hF4, 1'b1, model_frame(8'hF4), 1'b1);

    // Device goes silent after the third clock.
    wait_ready(200);
    d0 = done_n; e0 = err_n;
    start_req(8'h3C);
    t = 0;
    while (ps2_clk_oe && t < 1000) begin @(negedge clk); t++; end
    repeat (H) @(negedge clk);
    dev_falls(2);
    dev_clk_low = 1'b1;
    f3 = cyc;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    t = 0;
    while (err_n == e0 && t < 3 * TO) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("timeout_error_count", err_n - e0, 1);
    chk("timeout_latency_in_window", ((last_err_cyc - f3) >= TO && (last_err_cyc - f3) <= TO + 6) ? 1 : 0, 1);
    chk("timeout_clk_oe", ps2_clk_oe, 0);
    chk("timeout_data_oe", ps2_data_oe, 0);
    chk("timeout_tx_ready", tx_ready, 1);
`else
    repeat (2 * TO) @(negedge clk);
    chk("silent_busy", busy, 1);
    chk("silent_no_error", err_n - e0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("silent_rst_ready", tx_ready, 1);
`endif
    chk("silent_no_done", done_n - d0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
